// File: rtl/counter_4bit.sv
// Free-running 4-bit modulo counter with clock-enable prescaler.
// Steps once every DIV cycles, wraps at MOD, counts up or down per UP.
module counter_4bit #(
    parameter int DIV = 1,
    parameter int MOD = 16,
    parameter bit UP  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] cnt
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [3:0]    CNT_LAST = 4'(MOD - 1);

    generate
        if (DIV < 1 || DIV > (1 << 24) || MOD < 2 || MOD > 16) begin : g_bad_param
            $error("counter_4bit: illegal parameters DIV=%0d MOD=%0d", DIV, MOD);
        end
    endgenerate

    logic [PW-1:0] pre;
    logic          tick;

    // With DIV = 1 pre never leaves 0, so tick is permanently asserted.
    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            if (UP) begin
                cnt <= (cnt == CNT_LAST) ? 4'd0 : cnt + 4'd1;
            end else begin
                cnt <= (cnt == 4'd0) ? CNT_LAST : cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_counter_4bit.sv
// Directed self-checking bench for counter_4bit: default, prescaled and
// down-counting instances share one clock and reset.
module tb_counter_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cnt_def;
    logic [3:0] cnt_pre;
    logic [3:0] cnt_dn;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [3:0] up_seq [20] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
                                4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic [3:0] dn_seq [6]  = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd4};

    always #10 clk = ~clk;

    counter_4bit u_def (
        .clk  (clk),
        .rst_n(rst_n),
        .cnt  (cnt_def)
    );

    counter_4bit #(.DIV(4), .MOD(10), .UP(1'b1)) u_pre (
        .clk  (clk),
        .rst_n(rst_n),
        .cnt  (cnt_pre)
    );

    counter_4bit #(.DIV(1), .MOD(5), .UP(1'b0)) u_dn (
        .clk  (clk),
        .rst_n(rst_n),
        .cnt  (cnt_dn)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_def;
        rst_n = 1'b0;

        repeat (2) begin
            @(negedge clk);
            check("rst_def", cnt_def, 4'd0);
            check("rst_pre", cnt_pre, 4'd0);
            check("rst_dn",  cnt_dn,  4'd0);
        end
        rst_n = 1'b1;

        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            exp_def = (k <= 20) ? up_seq[k-1] : 4'(k % 16);
            check("def_seq", cnt_def, exp_def);
            check("pre_seq", cnt_pre, 4'((k / 4) % 10));
            check("pre_lt_mod", {3'b000, (cnt_pre < 4'd10)}, 4'd1);
            if (k <= 6) check("dn_seq", cnt_dn, dn_seq[k-1]);
            else        check("dn_seq", cnt_dn, 4'((5 - k % 5) % 5));
            if (k == 20) check("def_c20", cnt_def, 4'd4);
            if (k == 36) check("pre_c36", cnt_pre, 4'd9);
            if (k == 40) check("pre_c40", cnt_pre, 4'd0);
            if (k == 44) check("pre_c44", cnt_pre, 4'd1);
        end

        // Restart from reset, run to cnt_def = 7, then reset between edges.
        rst_n = 1'b0;
        #1;
        check("rst2_def", cnt_def, 4'd0);
        check("rst2_pre", cnt_pre, 4'd0);
        check("rst2_dn",  cnt_dn,  4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        check("run7_def", cnt_def, 4'd7);
        check("run7_pre", cnt_pre, 4'd1);
        check("run7_dn",  cnt_dn,  4'd3);

        #3;
        rst_n = 1'b0;
        #1;
        check("async_def", cnt_def, 4'd0);
        check("async_pre", cnt_pre, 4'd0);
        check("async_dn",  cnt_dn,  4'd0);
        @(negedge clk);
        check("hold_def", cnt_def, 4'd0);
        check("hold_dn",  cnt_dn,  4'd0);
        rst_n = 1'b1;

        @(negedge clk);
        check("restart_def", cnt_def, 4'd1);
        check("restart_pre", cnt_pre, 4'd0);
        check("restart_dn",  cnt_dn,  4'd4);
        repeat (3) @(negedge clk);
        check("restart4_def", cnt_def, 4'd4);
        check("restart4_pre", cnt_pre, 4'd1);
        check("restart4_dn",  cnt_dn,  4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
